// File: rtl/gol_video_pkg.sv
// Shared grid geometry, cell index type and control FSM encoding for the
// double-buffered VGA cell store.
package gol_video_pkg;

  localparam int unsigned GRID_COLS = 20;
  localparam int unsigned GRID_ROWS = 15;
  localparam int unsigned CELLS     = GRID_COLS * GRID_ROWS;
  localparam int unsigned VRAM_BASE = 212;

  typedef logic [8:0] cell_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    WAIT_VS
  } fsm_state_t;

endpackage

// File: rtl/vga_frame_buffer_if.sv
// Scan-out, CPU and swap/clear control signals of the frame buffer.
interface vga_frame_buffer_if;

  logic [8:0] vaddr;
  logic [7:0] vdata;
  logic       vsync_n;
  logic [8:0] cpu_addr;
  logic       cpu_we;
  logic [7:0] cpu_wdata;
  logic       cpu_re;
  logic [7:0] cpu_rdata;
  logic       swap_req;
  logic       clear_req;
  logic       swap_pending;
  logic       busy;
  logic       front_sel;
  logic       swap_done;

  modport master (
    output vaddr, vsync_n, cpu_addr, cpu_we, cpu_wdata, cpu_re, swap_req, clear_req,
    input  vdata, cpu_rdata, swap_pending, busy, front_sel, swap_done
  );

  modport slave (
    input  vaddr, vsync_n, cpu_addr, cpu_we, cpu_wdata, cpu_re, swap_req, clear_req,
    output vdata, cpu_rdata, swap_pending, busy, front_sel, swap_done
  );

endinterface

// File: rtl/vga_cell_bank.sv
// One bank of cell storage: a synchronous write port plus registered
// video and CPU read ports. Contents are not reset.
module vga_cell_bank
  import gol_video_pkg::*;
#(
  parameter int unsigned DEPTH = CELLS
) (
  input  logic       clk,
  input  logic       we,
  input  cell_idx_t  waddr,
  input  logic [7:0] wdata,
  input  cell_idx_t  vid_addr,
  output logic [7:0] vid_rdata,
  input  logic       cpu_re,
  input  cell_idx_t  cpu_addr,
  output logic [7:0] cpu_rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    vid_rdata <= mem[vid_addr];
    if (cpu_re) begin
      cpu_rdata <= mem[cpu_addr];
    end
  end

endmodule

// File: rtl/vga_frame_buffer.sv
// Double-buffered cell store feeding VGA scan-out; the CPU fills the back
// bank and the swap is committed on the falling edge of vsync_n.
module vga_frame_buffer #(
  parameter int unsigned BASE      = gol_video_pkg::VRAM_BASE,
  parameter int unsigned CELLS     = gol_video_pkg::CELLS,
  parameter logic [7:0]  CLEAR_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  vga_frame_buffer_if.slave bus
);

  import gol_video_pkg::*;

  localparam cell_idx_t BASE_A   = cell_idx_t'(BASE);
  localparam cell_idx_t LAST_IDX = cell_idx_t'(CELLS - 1);

  fsm_state_t state;
  cell_idx_t  clr_idx;
  logic       vsync_n_d;
  logic       busy;
  logic       swap_pending;
  logic       front_sel;
  logic       swap_done;

  logic       vs_fall;
  logic       vid_ok, cpu_ok;
  cell_idx_t  vid_idx, cpu_idx;
  logic       bank_we;
  cell_idx_t  bank_waddr;
  logic [7:0] bank_wdata;
  logic [7:0] vid_rd0, vid_rd1, cpu_rd0, cpu_rd1;
  logic       vid_ok_q, vid_sel_q, cpu_ok_q, cpu_sel_q;

  assign vs_fall = vsync_n_d & ~bus.vsync_n;

  assign vid_ok  = (bus.vaddr >= BASE_A);
  assign cpu_ok  = (bus.cpu_addr >= BASE_A);
  assign vid_idx = vid_ok ? (bus.vaddr - BASE_A) : '0;
  assign cpu_idx = cpu_ok ? (bus.cpu_addr - BASE_A) : '0;

  // The clear owns the back-bank write port; CPU writes during it are dropped.
  always_comb begin
    bank_we    = 1'b0;
    bank_waddr = cpu_idx;
    bank_wdata = bus.cpu_wdata;
    if (state == CLEAR) begin
      bank_we    = 1'b1;
      bank_waddr = clr_idx;
      bank_wdata = CLEAR_VAL;
    end else if (bus.cpu_we && cpu_ok) begin
      bank_we    = 1'b1;
    end
  end

  vga_cell_bank #(.DEPTH(CELLS)) u_bank0 (
    .clk       (clk),
    .we        (bank_we & front_sel),
    .waddr     (bank_waddr),
    .wdata     (bank_wdata),
    .vid_addr  (vid_idx),
    .vid_rdata (vid_rd0),
    .cpu_re    (bus.cpu_re),
    .cpu_addr  (cpu_idx),
    .cpu_rdata (cpu_rd0)
  );

  vga_cell_bank #(.DEPTH(CELLS)) u_bank1 (
    .clk       (clk),
    .we        (bank_we & ~front_sel),
    .waddr     (bank_waddr),
    .wdata     (bank_wdata),
    .vid_addr  (vid_idx),
    .vid_rdata (vid_rd1),
    .cpu_re    (bus.cpu_re),
    .cpu_addr  (cpu_idx),
    .cpu_rdata (cpu_rd1)
  );

  // Bank select is captured alongside each read so the commit cycle still
  // returns data from the old front bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_ok_q  <= 1'b0;
      vid_sel_q <= 1'b0;
      cpu_ok_q  <= 1'b0;
      cpu_sel_q <= 1'b0;
    end else begin
      vid_ok_q  <= vid_ok;
      vid_sel_q <= front_sel;
      if (bus.cpu_re) begin
        cpu_ok_q  <= cpu_ok;
        cpu_sel_q <= front_sel;
      end
    end
  end

  assign bus.vdata     = vid_ok_q ? (vid_sel_q ? vid_rd1 : vid_rd0) : 8'h00;
  assign bus.cpu_rdata = cpu_ok_q ? (cpu_sel_q ? cpu_rd1 : cpu_rd0) : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      clr_idx      <= '0;
      vsync_n_d    <= 1'b1;
      busy         <= 1'b0;
      swap_pending <= 1'b0;
      front_sel    <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      vsync_n_d <= bus.vsync_n;
      swap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear_req) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_idx <= '0;
            if (bus.swap_req) begin
              swap_pending <= 1'b1;
            end
          end else if (bus.swap_req) begin
            swap_pending <= 1'b1;
            state        <= WAIT_VS;
          end
        end
        CLEAR: begin
          if (bus.swap_req) begin
            swap_pending <= 1'b1;
          end
          if (clr_idx == LAST_IDX) begin
            busy    <= 1'b0;
            clr_idx <= '0;
            state   <= (swap_pending || bus.swap_req) ? WAIT_VS : IDLE;
          end else begin
            clr_idx <= clr_idx + 9'd1;
          end
        end
        WAIT_VS: begin
          if (vs_fall) begin
            front_sel    <= ~front_sel;
            swap_pending <= 1'b0;
            swap_done    <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy;
  assign bus.swap_pending = swap_pending;
  assign bus.front_sel    = front_sel;
  assign bus.swap_done    = swap_done;

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Scoreboard bench for vga_frame_buffer: directed stimulus queues expected
// read data and status; a monitor compares when the DUT presents it.
module tb_vga_frame_buffer;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } rd_exp_t;

  typedef struct {
    string      name;
    logic [3:0] exp;  // {busy, swap_pending, front_sel, swap_done}
  } st_exp_t;

  logic clk;
  logic reset;
  vga_frame_buffer_if bus();

  vga_frame_buffer #(.BASE(212), .CELLS(300), .CLEAR_VAL(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rd_exp_t cpu_q[$];
  rd_exp_t vid_q[$];
  st_exp_t st_q[$];
  logic    vid_chk = 1'b0;
  logic    cpu_chk = 1'b0;
  logic    arm_v   = 1'b0;
  logic    arm_c   = 1'b0;
  int      checks  = 0;
  int      passed  = 0;
  rd_exp_t ce, ve;
  st_exp_t se;
  logic [3:0] st_act;

  // Monitor: read data appears the cycle after the request is sampled.
  always @(posedge clk) begin
    arm_v <= vid_chk;
    arm_c <= cpu_chk;
  end

  always @(negedge clk) begin
    if (arm_c) begin
      checks++;
      if (cpu_q.size() == 0) begin
        $display("FAIL cpu_q_empty: got cpu_rdata %h with no expectation queued", bus.cpu_rdata);
      end else begin
        ce = cpu_q.pop_front();
        if (bus.cpu_rdata !== ce.exp)
          $display("FAIL %s: cpu_rdata got %h want %h", ce.name, bus.cpu_rdata, ce.exp);
        else
          passed++;
      end
    end
    if (arm_v) begin
      checks++;
      if (vid_q.size() == 0) begin
        $display("FAIL vid_q_empty: got vdata %h with no expectation queued", bus.vdata);
      end else begin
        ve = vid_q.pop_front();
        if (bus.vdata !== ve.exp)
          $display("FAIL %s: vdata got %h want %h", ve.name, bus.vdata, ve.exp);
        else
          passed++;
      end
    end
    while (st_q.size() > 0) begin
      se = st_q.pop_front();
      st_act = {bus.busy, bus.swap_pending, bus.front_sel, bus.swap_done};
      checks++;
      if (st_act !== se.exp)
        $display("FAIL %s: status {busy,pend,fsel,done} got %b want %b", se.name, st_act, se.exp);
      else
        passed++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b0;
    bus.swap_req  = 1'b0;
    bus.clear_req = 1'b0;
    vid_chk       = 1'b0;
    cpu_chk       = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_we    = 1'b1;
    cyc();
  endtask

  task automatic vid_rd(input string n, input logic [8:0] a, input logic [7:0] e);
    bus.vaddr = a;
    vid_chk   = 1'b1;
    vid_q.push_back('{name: n, exp: e});
    cyc();
  endtask

  task automatic rd2(input string n, input logic [8:0] va, input logic [7:0] ve_, input logic [8:0] ca, input logic [7:0] ce_);
    bus.vaddr    = va;
    bus.cpu_addr = ca;
    bus.cpu_re   = 1'b1;
    vid_chk      = 1'b1;
    cpu_chk      = 1'b1;
    vid_q.push_back('{name: n, exp: ve_});
    cpu_q.push_back('{name: n, exp: ce_});
    cyc();
  endtask

  task automatic st(input string n, input logic [3:0] e);
    st_q.push_back('{name: n, exp: e});
  endtask

  task automatic note(input string n, input int got, input int want);
    checks++;
    if (got !== want) $display("FAIL %s: got %0d want %0d", n, got, want);
    else passed++;
  endtask

  task automatic count_busy(input string n);
    int cnt;
    cnt = 0;
    while (bus.busy && cnt < 1000) begin
      if (cnt == 295) begin
        bus.cpu_addr  = 9'd300;
        bus.cpu_wdata = 8'h55;
        bus.cpu_we    = 1'b1;
      end
      cnt++;
      cyc();
    end
    note(n, cnt, 300);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.vaddr     = '0;
    bus.vsync_n   = 1'b1;
    bus.cpu_addr  = '0;
    bus.cpu_we    = 1'b0;
    bus.cpu_wdata = '0;
    bus.cpu_re    = 1'b0;
    bus.swap_req  = 1'b0;
    bus.clear_req = 1'b0;
    repeat (3) cyc();
    st("reset_status", 4'b0000);
    note("reset_vdata", int'(bus.vdata), 0);
    note("reset_cpu_rdata", int'(bus.cpu_rdata), 0);
    reset = 1'b0;
    cyc();

    // Basic swap: writes land in bank 1, which becomes front on the vsync fall.
    wr(9'd212, 8'h0F);
    wr(9'd511, 8'h05);
    bus.swap_req = 1'b1;
    cyc();
    st("swap_pending", 4'b0100);
    bus.vsync_n = 1'b0;
    cyc();
    st("swap_done_pulse", 4'b0011);
    bus.vsync_n = 1'b1;
    cyc();
    st("swap_done_drop", 4'b0010);
    vid_rd("vid_212", 9'd212, 8'h0F);
    vid_rd("vid_511", 9'd511, 8'h05);

    // Out-of-window accesses.
    wr(9'd100, 8'hAA);
    rd2("oow_read", 9'd211, 8'h00, 9'd100, 8'h00);
    rd2("front_intact_212", 9'd212, 8'h0F, 9'd212, 8'h0F);
    rd2("front_intact_511", 9'd511, 8'h05, 9'd511, 8'h05);
    cyc();

    // Swap waits indefinitely for vsync; a repeated request is absorbed.
    bus.swap_req = 1'b1;
    cyc();
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) bus.swap_req = 1'b1;
      cyc();
      st("wait_hold", 4'b0110);
    end
    bus.vsync_n = 1'b0;
    cyc();
    st("commit_after_wait", 4'b0001);
    bus.vsync_n = 1'b1;
    cyc();
    st("after_commit", 4'b0000);
    bus.vsync_n = 1'b0;
    cyc();
    st("no_second_toggle", 4'b0000);
    bus.vsync_n = 1'b1;
    cyc();

    // Clear plus swap in one cycle; back bank (1) pre-filled with 07.
    for (int a = 212; a < 512; a++) wr(9'(a), 8'h07);
    bus.clear_req = 1'b1;
    bus.swap_req  = 1'b1;
    cyc();
    st("clear_start", 4'b1100);
    count_busy("clear_len");
    st("clear_then_wait", 4'b0100);
    repeat (5) cyc();
    st("clear_wait_hold", 4'b0100);
    bus.vsync_n = 1'b0;
    cyc();
    st("clear_commit", 4'b0011);
    bus.vsync_n = 1'b1;
    cyc();
    for (int a = 212; a < 512; a++) rd2("cleared_cell", 9'(a), 8'h00, 9'(a), 8'h00);
    rd2("cleared_300", 9'd300, 8'h00, 9'd300, 8'h00);

    // CPU write coinciding with the commit lands in the new front.
    bus.swap_req = 1'b1;
    cyc();
    st("pre_commit_write", 4'b0110);
    bus.vsync_n   = 1'b0;
    bus.cpu_addr  = 9'd250;
    bus.cpu_wdata = 8'h09;
    bus.cpu_we    = 1'b1;
    cyc();
    st("commit_with_write", 4'b0001);
    bus.vsync_n = 1'b1;
    rd2("commit_write_250", 9'd250, 8'h09, 9'd250, 8'h09);

    // Reset mid-clear with front_sel=1 aborts cleanly.
    bus.swap_req = 1'b1;
    cyc();
    bus.vsync_n = 1'b0;
    cyc();
    bus.vsync_n = 1'b1;
    cyc();
    st("pre_abort_front", 4'b0010);
    bus.clear_req = 1'b1;
    cyc();
    repeat (150) cyc();
    st("mid_clear", 4'b1010);
    reset = 1'b1;
    cyc();
    st("reset_abort", 4'b0000);
    reset = 1'b0;
    cyc();
    bus.clear_req = 1'b1;
    cyc();
    count_busy("clear_len_after_reset");
    st("idle_after_clear", 4'b0000);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_frame_buffer.md
Name: vga_frame_buffer

Overview:
- Double-buffered cell store that sits directly upstream of the VGA scan-out stage.
- Answers the scan-out's 9-bit vaddr with 8-bit vdata from the front bank, using a 20x15 grid at cell addresses 212..511.
- The CPU reads the current generation (front bank) and writes the next generation (back bank).
- A bank swap is requested by the CPU and committed only at the start of vertical sync, so the displayed frame never tears.

Parameters:
- BASE, 212, first cell address; the window is BASE..BASE+CELLS-1.
- CELLS, 300, number of cells per bank (20 cols x 15 rows).
- CLEAR_VAL, 8'h00, value written to every back-bank cell by a clear.

Ports:
- clk  in  1  system clock; also the pixel clock.
- reset  in  1  synchronous, active-high reset.
- vaddr  in  9  cell address from the VGA stage.
- vdata  out  8  front-bank cell value; 1-cycle latency.
- vsync_n  in  1  active-low vertical sync from the VGA stage (already registered there).
- cpu_addr  in  9  CPU cell address.
- cpu_we  in  1  write strobe; writes the back bank.
- cpu_wdata  in  8  write data.
- cpu_re  in  1  read strobe; reads the front bank.
- cpu_rdata  out  8  read data; valid the cycle after cpu_re, held until the next read.
- swap_req  in  1  single-cycle swap request pulse.
- clear_req  in  1  single-cycle request to fill the back bank with CLEAR_VAL.
- swap_pending  out  1  a swap is requested but not yet committed.
- busy  out  1  a clear is in progress.
- front_sel  out  1  index of the bank currently displayed.
- swap_done  out  1  1-cycle pulse in the cycle after the swap commits.

Behaviour:
- Reset values: vdata=0, cpu_rdata=0, swap_pending=0, busy=0, front_sel=0, swap_done=0, FSM=IDLE, clear index=0. Bank contents are not reset.
- Address mapping:
  - Cell index = addr - BASE.
  - An address is in-window iff addr >= BASE; every 9-bit address >= 212 is < 512 = BASE+CELLS.
  - Out-of-window reads return 8'h00.
  - Out-of-window writes are dropped.
- Video read:
  - vdata(t+1) = front[vaddr(t)], registered every cycle.
  - There is no enable and no stall.
  - The scan-out stage tolerates the 1-pixel shift.
- CPU read: cpu_rdata(t+1) = front[cpu_addr(t)] when cpu_re(t)=1; otherwise cpu_rdata holds.
- CPU write:
  - When cpu_we=1 in IDLE or WAIT_VS, back[idx] is written at the clock edge.
  - Writes while busy=1 are dropped.
- Vsync edge: vs_fall = vsync_n_d & ~vsync_n, where vsync_n_d is vsync_n delayed one cycle (reset value 1).
- FSM states:
  - IDLE:
    - clear_req moves to CLEAR, sets busy=1 and index=0.
    - swap_req sets swap_pending=1 and moves to WAIT_VS.
    - If both arrive in the same cycle: go to CLEAR, set swap_pending=1, and enter WAIT_VS after the clear.
  - CLEAR:
    - Writes back[index]=CLEAR_VAL and increments index, one cell per cycle (300 cycles).
    - At index==CELLS-1: busy drops in the next cycle, then go to WAIT_VS if swap_pending, else IDLE.
    - swap_req while clearing sets swap_pending. clear_req while clearing is ignored.
  - WAIT_VS:
    - On vs_fall, front_sel toggles and swap_pending clears.
    - swap_done pulses in the following cycle, then return to IDLE.
    - clear_req in WAIT_VS is ignored.
    - swap_req in WAIT_VS is absorbed; no second swap is queued.
- Simultaneous events:
  - A CPU write in the cycle a swap commits lands in the pre-swap back bank, which becomes the new front.
  - A swap_req in the same cycle as a commit is dropped.
  - The vaddr and cpu_re reads in the commit cycle use the old front_sel.
- vs_fall while not in WAIT_VS: no effect.
- reset mid-CLEAR or mid-WAIT_VS: aborts to IDLE with all outputs at their reset values.
  - The partially cleared bank is left as-is.
  - front_sel returns to 0.

Decomposition:
- Package gol_video_pkg:
  - GRID_COLS=20, GRID_ROWS=15, CELLS=300, VRAM_BASE=212.
  - Cell index type logic [8:0].
  - FSM enum {IDLE, CLEAR, WAIT_VS}.
- Sub-module vga_cell_bank, instantiated twice:
  - 300x8 storage with one synchronous write port and two registered read ports (video and CPU).
  - The top level muxes outputs and write enables by front_sel.

Test Plan:
- Reset, write 8'h0F to addr 212 and 8'h05 to 511, swap_req, drive vsync_n 1->0 -> swap_done pulses one cycle after the edge; front_sel=1; vaddr=212 gives vdata=8'h0F next cycle; vaddr=511 gives 8'h05.
- Write 8'hAA to addr 100, then cpu_re at addr 100 and vaddr=211 -> cpu_rdata=8'h00, vdata=8'h00, and neither bank is modified.
- swap_req with vsync_n held at 1 for 1000 cycles -> front_sel unchanged and swap_pending=1 throughout; the vsync_n fall commits the swap; a second swap_req in WAIT_VS produces only one toggle.
- Pre-fill the back bank with 8'h07, clear_req and swap_req in the same cycle, cpu_we at addr 300 during CLEAR -> busy=1 for exactly 300 cycles; the swap waits for the next vsync fall; all 300 front cells read 8'h00, including addr 300.
- CPU write of 8'h09 to addr 250 in the same cycle as vs_fall commits -> after the swap, vdata for vaddr=250 is 8'h09.
- Assert reset at clear index 150 -> next cycle busy=0, front_sel=0, FSM=IDLE; a subsequent clear_req runs a full 300 cycles.
